mmio_in_ports: RTL

Memory-mapped input-port responder. It is the read-side counterpart of the processor's PORT_OUT_A..D store decode. Each of NUM_CH external producers pushes a word through a valid/ready handshake into a one-entry holding slot. The core retrieves the word with a load from the block's address window, one cycle after the request, matching MEMORY read timing. A status word exposes per-channel full flags and sticky empty-read error flags; the error flags are write-1-to-clear.

---
 rtl/mmio_in_ports_pkg.sv | 13 +
 rtl/mmio_in_ports_slot.sv | 33 +++
 rtl/mmio_in_ports.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mmio_in_ports_pkg.sv
// Shared MMIO map for the input-port window.
// The processor decode and the bench use the same register offsets and STATUS fields.
package mmio_in_ports_pkg;

    // Word offsets from BASE_ADDR.
    localparam int unsigned DATA_OFS   = 0;   // DATA_k at DATA_OFS + k
    localparam int unsigned STATUS_OFS = 8;

    // STATUS bit-field positions.
    localparam int unsigned FULL_LSB = 0;
    localparam int unsigned ERR_LSB  = 8;

endpackage : mmio_in_ports_pkg

// File: rtl/mmio_in_ports_slot.sv
// One-entry holding slot for a single input channel.
//   clk, reset : clock, asynchronous active-high reset
//   push       : capture push_data and mark the slot full (only issued while empty)
//   pop        : mark the slot empty (only issued while full)
//   push_data  : word offered by the producer
//   full       : slot holds an unread word
//   data       : held word
module in_port_slot #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    // Push and pop are mutually exclusive: push needs ~full, pop needs full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= 1'b0;
            data <= '0;
        end else if (push) begin
            full <= 1'b1;
            data <= push_data;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule : in_port_slot

// File: rtl/mmio_in_ports.sv
// Memory-mapped input-port responder: NUM_CH producers push words into
// one-entry slots; the core reads them back through a load window.
//   clk, reset : clock, asynchronous active-high reset
//   halt       : pipeline stall, freezes read side effects and rd_data/rd_hit
//   in_valid   : per-channel offer,   in_data : slice k = [k*WIDTH +: WIDTH]
//   in_ready   : per-channel slot empty (combinational from slot state)
//   rd_en/rd_addr -> rd_data/rd_hit : registered load response, 1-cycle latency
//   wr_en/wr_addr/wr_data : store port, W1C of STATUS error flags
module mmio_in_ports
    import mmio_in_ports_pkg::*;
#(
    parameter int unsigned     WIDTH     = 32,
    parameter int unsigned     NUM_CH    = 4,
    parameter logic [WIDTH-1:0] BASE_ADDR = WIDTH'(32'h4000_0010)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    halt,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    rd_en,
    input  logic [WIDTH-1:0]        rd_addr,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    rd_hit,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_addr,
    input  logic [WIDTH-1:0]        wr_data
);

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] data_sel;
    logic [NUM_CH-1:0] err;
    logic [NUM_CH-1:0] err_set;
    logic [NUM_CH-1:0] err_clr;
    logic [NUM_CH-1:0] err_nxt;
    logic [WIDTH-1:0]  slot_data [NUM_CH];
    logic [WIDTH-1:0]  rd_off;
    logic [WIDTH-1:0]  wr_off;
    logic [WIDTH-1:0]  status_word;
    logic [WIDTH-1:0]  rd_data_nxt;
    logic              rd_hit_nxt;
    logic              rd_accept;
    logic              status_sel;
    logic              wr_status;
    logic              unused_wr_bits;

    // Offsets from BASE_ADDR; equality on the full word gives an exact-address decode.
    assign rd_off = rd_addr - BASE_ADDR;
    assign wr_off = wr_addr - BASE_ADDR;

    assign in_ready = ~full;
    assign push     = in_valid & ~full;

    // Only the error-clear field of a store is meaningful.
    assign unused_wr_bits = ^{wr_data[WIDTH-1:ERR_LSB+NUM_CH], wr_data[ERR_LSB-1:0]};

    // Slot array.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        in_port_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .reset     (reset),
            .push      (push[k]),
            .pop       (pop[k]),
            .push_data (in_data[k*WIDTH +: WIDTH]),
            .full      (full[k]),
            .data      (slot_data[k])
        );
    end

    // Address decode, pop/error side effects and W1C.
    always_comb begin
        data_sel = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            data_sel[k] = (rd_off == WIDTH'(DATA_OFS + k));
        end
        status_sel = (rd_off == WIDTH'(STATUS_OFS));
        wr_status  = wr_en && (wr_off == WIDTH'(STATUS_OFS));
        rd_accept  = rd_en && !halt;

        pop     = {NUM_CH{rd_accept}} & data_sel & full;
        err_set = {NUM_CH{rd_accept}} & data_sel & ~full;
        err_clr = {NUM_CH{wr_status}} & wr_data[ERR_LSB +: NUM_CH];
        // A set in the same cycle as a clear wins.
        err_nxt = (err & ~err_clr) | err_set;

        status_word                     = '0;
        status_word[FULL_LSB +: NUM_CH] = full;
        status_word[ERR_LSB +: NUM_CH]  = err;
    end

    // Read response mux; halt freezes, idle drops rd_hit but keeps rd_data.
    always_comb begin
        rd_data_nxt = rd_data;
        rd_hit_nxt  = rd_hit;
        if (!halt) begin
            if (!rd_en) begin
                rd_hit_nxt = 1'b0;
            end else begin
                rd_data_nxt = '0;
                rd_hit_nxt  = 1'b0;
                if (status_sel) begin
                    rd_data_nxt = status_word;
                    rd_hit_nxt  = 1'b1;
                end
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    if (data_sel[k]) begin
                        rd_hit_nxt = 1'b1;
                        if (full[k]) begin
                            rd_data_nxt = slot_data[k];
                        end
                    end
                end
            end
        end
    end

    // Response and error-flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
            rd_hit  <= 1'b0;
            err     <= '0;
        end else begin
            rd_data <= rd_data_nxt;
            rd_hit  <= rd_hit_nxt;
            err     <= err_nxt;
        end
    end

endmodule : mmio_in_ports
